// File: rtl/regfile_write_arbiter_pkg.sv
// Register-file constants and shared types for the writeback arbiter.
// XZR_IDX is the hard-wired zero register; writes to it are discarded and counted.
package regfile_write_arbiter_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bundle: valid/dest/data from each source, one-hot grant back.
// Requester i occupies slice i of each packed vector.
interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 64
);

   logic [NUM_REQ-1:0]            ReqValid;
   logic [REG_ADDR_W*NUM_REQ-1:0] ReqRW;
   logic [DATA_W*NUM_REQ-1:0]     ReqData;
   logic [NUM_REQ-1:0]            ReqGrant;

   modport master (
      output ReqValid,
      output ReqRW,
      output ReqData,
      input  ReqGrant
   );

   modport slave (
      input  ReqValid,
      input  ReqRW,
      input  ReqData,
      output ReqGrant
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at ptr and rotates upward,
// producing a one-hot grant plus the encoded winner index.
module regfile_write_arbiter_rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   winner,
   output logic               any
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
      idx    = 0;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      if (en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[PTR_W'(idx)]) begin
               any                = 1'b1;
               grant[PTR_W'(idx)] = 1'b1;
               winner             = PTR_W'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources with round-robin
// arbitration, posedge-registered port outputs, in-flight forwarding and an XZR drop counter.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 64,
   parameter int CNT_W   = 8
) (
   input  logic                   Clk,
   input  logic                   ResetL,
   input  logic                   Stall,
   regfile_write_arbiter_if.slave req_if,
   input  reg_addr_t              RA,
   input  reg_addr_t              RB,
   output logic                   RegWr,
   output reg_addr_t              RW,
   output logic [DATA_W-1:0]      BusW,
   output logic                   FwdHitA,
   output logic                   FwdHitB,
   output logic [DATA_W-1:0]      FwdData,
   output logic [CNT_W-1:0]       DropCnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   winner;
   logic [NUM_REQ-1:0] grant;
   logic               xfer;

   logic               reg_wr_q, reg_wr_d;
   reg_addr_t          rw_q, rw_d;
   logic [DATA_W-1:0]  bus_w_q, bus_w_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   reg_addr_t          req_rw   [NUM_REQ];
   logic [DATA_W-1:0]  req_data [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_rw[g]   = req_if.ReqRW[g*REG_ADDR_W +: REG_ADDR_W];
      assign req_data[g] = req_if.ReqData[g*DATA_W +: DATA_W];
   end

   // Grants are suppressed while in reset so a grant without a completed edge never looks like a transfer.
   regfile_write_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .en     (ResetL & ~Stall),
      .req    (req_if.ReqValid),
      .ptr    (rr_ptr_q),
      .grant  (grant),
      .winner (winner),
      .any    (xfer)
   );

   assign req_if.ReqGrant = grant;

   always_comb begin
      reg_wr_d   = 1'b0;
      rw_d       = rw_q;
      bus_w_d    = bus_w_q;
      drop_cnt_d = drop_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         if (req_rw[winner] == XZR_IDX) begin
            if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
         end else begin
            reg_wr_d = 1'b1;
            rw_d     = req_rw[winner];
            bus_w_d  = req_data[winner];
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge ResetL) begin
      if (!ResetL) begin
         reg_wr_q   <= 1'b0;
         rw_q       <= XZR_IDX;
         bus_w_q    <= '0;
         drop_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         reg_wr_q   <= reg_wr_d;
         rw_q       <= rw_d;
         bus_w_q    <= bus_w_d;
         drop_cnt_q <= drop_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign RegWr   = reg_wr_q;
   assign RW      = rw_q;
   assign BusW    = bus_w_q;
   assign DropCnt = drop_cnt_q;

   assign FwdHitA = reg_wr_q && (RA == rw_q) && (RA != XZR_IDX);
   assign FwdHitB = reg_wr_q && (RB == rw_q) && (RB != XZR_IDX);
   assign FwdData = bus_w_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, corner-case
// sequences, then randomized traffic against a behavioural round-robin model.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 64;
   localparam int CNT_W   = 8;

   localparam logic [63:0] D0 = 64'h0000_0000_DEAD_BEEF;
   localparam logic [63:0] D1 = 64'h1111_0000_0000_1111;
   localparam logic [63:0] D2 = 64'h2222_0000_0000_2222;

   logic             Clk = 1'b0;
   logic             ResetL = 1'b1;
   logic             Stall = 1'b0;
   reg_addr_t        RA = '0, RB = '0;
   logic             RegWr, FwdHitA, FwdHitB;
   reg_addr_t        RW;
   logic [DATA_W-1:0] BusW, FwdData;
   logic [CNT_W-1:0] DropCnt;

   regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) req_if ();

   regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .Clk     (Clk),
      .ResetL  (ResetL),
      .Stall   (Stall),
      .req_if  (req_if.slave),
      .RA      (RA),
      .RB      (RB),
      .RegWr   (RegWr),
      .RW      (RW),
      .BusW    (BusW),
      .FwdHitA (FwdHitA),
      .FwdHitB (FwdHitB),
      .FwdData (FwdData),
      .DropCnt (DropCnt)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   logic [NUM_REQ-1:0] valid_a;
   reg_addr_t          rw_a   [NUM_REQ];
   logic [63:0]        data_a [NUM_REQ];

   typedef struct {
      logic              stall;
      logic [NUM_REQ-1:0] valid;
      logic [NUM_REQ-1:0] grant;
      logic              regwr;
      reg_addr_t         rw;
      logic [63:0]       busw;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive();
      req_if.ReqValid = valid_a;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_if.ReqRW[i*REG_ADDR_W +: REG_ADDR_W] = rw_a[i];
         req_if.ReqData[i*DATA_W +: DATA_W]       = data_a[i];
      end
   endtask

   function automatic logic exp_fwd(input logic wr, input reg_addr_t rw, input reg_addr_t ra);
      return wr && (rw == ra) && (ra != XZR_IDX);
   endfunction

   // Reference model state for the random phase.
   int          m_ptr, m_drop, win;
   logic        m_regwr;
   reg_addr_t   m_rw;
   logic [63:0] m_busw;
   logic [NUM_REQ-1:0] m_grant;

   initial begin
      vecs[0]  = '{1'b0, 3'b001, 3'b001, 1'b1, 5'd5,  D0};
      vecs[1]  = '{1'b0, 3'b000, 3'b000, 1'b0, 5'd5,  D0};
      vecs[2]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd9,  D1};
      vecs[3]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd12, D2};
      vecs[4]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd5,  D0};
      vecs[5]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd9,  D1};
      vecs[6]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd12, D2};
      vecs[7]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd5,  D0};
      vecs[8]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd9,  D1};
      vecs[9]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd12, D2};
      vecs[10] = '{1'b1, 3'b101, 3'b000, 1'b0, 5'd12, D2};
      vecs[11] = '{1'b1, 3'b101, 3'b000, 1'b0, 5'd12, D2};
      vecs[12] = '{1'b0, 3'b101, 3'b001, 1'b1, 5'd5,  D0};
      vecs[13] = '{1'b0, 3'b101, 3'b100, 1'b1, 5'd12, D2};
      vecs[14] = '{1'b0, 3'b100, 3'b100, 1'b1, 5'd12, D2};

      // Reset with all requesters valid: no grant, port in its reset state.
      valid_a = 3'b111;
      rw_a[0] = 5'd5;  rw_a[1] = 5'd9;  rw_a[2] = 5'd12;
      data_a[0] = D0;  data_a[1] = D1;  data_a[2] = D2;
      drive();
      #2 ResetL = 1'b0;
      #1;
      check("reset_grant", req_if.ReqGrant, 3'b000);
      check("reset_regwr", RegWr, 1'b0);
      check("reset_rw", RW, 5'd31);
      check("reset_busw", BusW, 64'h0);
      check("reset_dropcnt", DropCnt, 8'h00);
      repeat (2) @(posedge Clk);
      valid_a = '0;
      drive();
      @(negedge Clk);
      ResetL = 1'b1;
      @(posedge Clk);
      #1;

      // Directed vector table from RrPtr=0.
      RA = 5'd5;
      RB = 5'd12;
      for (int t = 0; t < 15; t++) begin
         Stall   = vecs[t].stall;
         valid_a = vecs[t].valid;
         drive();
         #1;
         check($sformatf("vec%0d_grant", t), req_if.ReqGrant, vecs[t].grant);
         @(posedge Clk);
         #1;
         check($sformatf("vec%0d_regwr", t), RegWr, vecs[t].regwr);
         check($sformatf("vec%0d_rw", t), RW, vecs[t].rw);
         check($sformatf("vec%0d_busw", t), BusW, vecs[t].busw);
         check($sformatf("vec%0d_fwda", t), FwdHitA, exp_fwd(vecs[t].regwr, vecs[t].rw, RA));
         check($sformatf("vec%0d_fwdb", t), FwdHitB, exp_fwd(vecs[t].regwr, vecs[t].rw, RB));
      end
      Stall = 1'b0;

      // Forwarding of the in-flight write; XZR read port never hits.
      valid_a = 3'b001;
      rw_a[0] = 5'd7;
      data_a[0] = 64'h0000_0000_0000_CAFE;
      RA = 5'd7;
      RB = 5'd31;
      drive();
      #1;
      check("fwd_grant", req_if.ReqGrant, 3'b001);
      @(posedge Clk);
      #1;
      check("fwd_hita", FwdHitA, 1'b1);
      check("fwd_hitb", FwdHitB, 1'b0);
      check("fwd_data", FwdData, 64'h0000_0000_0000_CAFE);
      valid_a = '0;
      drive();
      @(posedge Clk);
      #1;
      check("fwd_idle_hita", FwdHitA, 1'b0);
      check("fwd_idle_hitb", FwdHitB, 1'b0);
      check("fwd_idle_rw", RW, 5'd7);

      // XZR writes are granted, discarded and counted with saturation.
      valid_a = 3'b010;
      rw_a[1] = XZR_IDX;
      data_a[1] = 64'h5555;
      drive();
      #1;
      check("drop_grant", req_if.ReqGrant, 3'b010);
      @(posedge Clk);
      #1;
      check("drop_regwr", RegWr, 1'b0);
      check("drop_cnt1", DropCnt, 8'h01);
      check("drop_rw_hold", RW, 5'd7);
      check("drop_busw_hold", BusW, 64'h0000_0000_0000_CAFE);
      repeat (253) @(posedge Clk);
      #1;
      check("drop_cnt254", DropCnt, 8'hFE);
      @(posedge Clk);
      #1;
      check("drop_cnt255", DropCnt, 8'hFF);
      repeat (5) @(posedge Clk);
      #1;
      check("drop_cnt_sat", DropCnt, 8'hFF);
      check("drop_sat_regwr", RegWr, 1'b0);

      // Reset while a write is in flight; a grant seen during reset is not a transfer.
      valid_a = 3'b001;
      rw_a[0] = 5'd3;
      data_a[0] = 64'hABCD;
      drive();
      @(posedge Clk);
      #1;
      check("mid_pre_regwr", RegWr, 1'b1);
      valid_a = 3'b100;
      rw_a[2] = 5'd20;
      data_a[2] = 64'h2020_2020;
      drive();
      #2 ResetL = 1'b0;
      #1;
      check("mid_rst_regwr", RegWr, 1'b0);
      check("mid_rst_rw", RW, 5'd31);
      check("mid_rst_dropcnt", DropCnt, 8'h00);
      check("mid_rst_grant", req_if.ReqGrant, 3'b000);
      @(negedge Clk);
      ResetL = 1'b1;
      #1;
      check("mid_post_grant", req_if.ReqGrant, 3'b100);
      @(posedge Clk);
      #1;
      check("mid_post_regwr", RegWr, 1'b1);
      check("mid_post_rw", RW, 5'd20);
      check("mid_post_busw", BusW, 64'h2020_2020);

      // Randomized traffic against the behavioural model.
      m_ptr = 0; m_drop = 0; m_regwr = 1'b1; m_rw = 5'd20; m_busw = 64'h2020_2020;
      valid_a = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rw_a[i] = 5'd0;
         data_a[i] = '0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
         Stall = ($urandom % 5 == 0);
         RA = ($urandom % 2 == 0) ? m_rw : reg_addr_t'($urandom % 32);
         RB = ($urandom % 2 == 0) ? m_rw : reg_addr_t'($urandom % 32);
         drive();
         #1;
         m_grant = '0;
         win = -1;
         if (!Stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (win < 0 && valid_a[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
            end
         end
         if (win >= 0) m_grant[win] = 1'b1;
         check($sformatf("rnd%0d_grant", cyc), req_if.ReqGrant, m_grant);
         check($sformatf("rnd%0d_fwda", cyc), FwdHitA, exp_fwd(m_regwr, m_rw, RA));
         check($sformatf("rnd%0d_fwdb", cyc), FwdHitB, exp_fwd(m_regwr, m_rw, RB));
         check($sformatf("rnd%0d_fwdd", cyc), FwdData, m_busw);
         @(posedge Clk);
         #1;
         m_regwr = 1'b0;
         if (win >= 0) begin
            m_ptr = (win + 1) % NUM_REQ;
            if (rw_a[win] == XZR_IDX) begin
               if (m_drop < 255) m_drop++;
            end else begin
               m_regwr = 1'b1;
               m_rw    = rw_a[win];
               m_busw  = data_a[win];
            end
         end
         check($sformatf("rnd%0d_regwr", cyc), RegWr, m_regwr);
         check($sformatf("rnd%0d_rw", cyc), RW, m_rw);
         check($sformatf("rnd%0d_busw", cyc), BusW, m_busw);
         check($sformatf("rnd%0d_drop", cyc), DropCnt, 64'(m_drop));
         // Pending requests hold; granted or idle requesters pick new work.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i == win || !valid_a[i]) begin
               valid_a[i] = ($urandom % 2 == 0);
               rw_a[i]    = ($urandom % 4 == 0) ? XZR_IDX : reg_addr_t'($urandom % 32);
               data_a[i]  = {$urandom, $urandom};
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
